// File: rtl/transmissor_pesos.sv
// transmissor_pesos: sends six latched BCD weight digits as six ASCII
// characters on an asynchronous serial line. The first character is max digit 1
// and the last is current digit 0. Data goes out LSB first.
// The default frame is 8N1. Defining TRANSMISSOR_PARIDADE_EN adds an even
// parity bit after data bit 7, which makes the frame 8E1.
//
// state     | meaning
// INICIAL   | idle, line high, waits for partida
// PREPARA   | builds the frame for the current character
// TRANSMITE | shifts frame bits out, DIVISOR cycles per bit
// PROXIMO   | advances the character index, or ends after the sixth
// FINAL     | one-cycle pronto pulse, then back to idle
module transmissor_pesos #(
  parameter int DIVISOR = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [23:0] dados,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam logic [3:0] INICIAL   = 4'd0;
  localparam logic [3:0] PREPARA   = 4'd1;
  localparam logic [3:0] TRANSMITE = 4'd2;
  localparam logic [3:0] PROXIMO   = 4'd3;
  localparam logic [3:0] FINAL     = 4'd15;

`ifdef TRANSMISSOR_PARIDADE_EN
  localparam int FRAME_W = 11;
`else
  localparam int FRAME_W = 10;
`endif

  localparam int                BAUD_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(DIVISOR - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
  localparam logic [3:0]        BIT_LAST = 4'(FRAME_W - 1);
  localparam logic [2:0]        IDX_LAST = 3'd5;

  logic [3:0]         state_q, state_d;
  logic [23:0]        dados_q, dados_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         bit_q, bit_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  logic [3:0]         nibble;
  logic [7:0]         char_ascii;
  logic [FRAME_W-1:0] frame;

  // Pick the digit for the current character index, most significant first.
  always_comb begin
    case (idx_q)
      3'd0:    nibble = dados_q[23:20];
      3'd1:    nibble = dados_q[19:16];
      3'd2:    nibble = dados_q[15:12];
      3'd3:    nibble = dados_q[11:8];
      3'd4:    nibble = dados_q[7:4];
      default: nibble = dados_q[3:0];
    endcase
  end

  // Digits above 9 are deliberately passed through and become 0x3A..0x3F.
  assign char_ascii = {4'h3, nibble};

`ifdef TRANSMISSOR_PARIDADE_EN
  assign frame = {1'b1, ^char_ascii, char_ascii, 1'b0};
`else
  assign frame = {1'b1, char_ascii, 1'b0};
`endif

  // Next-state logic for the sequencer, the counters and the shift register.
  always_comb begin
    state_d = state_q;
    dados_d = dados_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    case (state_q)
      INICIAL: begin
        if (partida) begin
          dados_d = dados;
          idx_d   = 3'd0;
          state_d = PREPARA;
        end
      end
      PREPARA: begin
        shift_d = frame;
        bit_d   = 4'd0;
        baud_d  = '0;
        state_d = TRANSMITE;
      end
      TRANSMITE: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = PROXIMO;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      PROXIMO: begin
        if (idx_q == IDX_LAST) begin
          state_d = FINAL;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = PREPARA;
        end
      end
      FINAL:   state_d = INICIAL;
      default: state_d = INICIAL;
    endcase
  end

  // State registers; synchronous reset abandons any character in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
      dados_q <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      dados_q <= dados_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign saida_serial = (state_q == TRANSMITE) ? shift_q[0] : 1'b1;
  assign ocupado      = (state_q == PREPARA) || (state_q == TRANSMITE) ||
                        (state_q == PROXIMO);
  assign pronto       = (state_q == FINAL);
  assign db_estado    = state_q;

endmodule

// File: doc/transmissor_pesos.md
# transmissor_pesos

Serial transmitter for the weight-scale subsystem: on a start pulse it latches six BCD digits (max weight, min weight, current weight, two digits each) and sends them as six ASCII characters over an asynchronous serial line. It is the opposite end of the serial receive path that fills the 48-bit weight register, and it uses the same byte order, so a loopback of `saida_serial` into that receiver reproduces the digits. It sits beside the existing datapath and is driven by a control unit or debug button.

## Interface
- `DIVISOR`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal values are ≥ 2.
- `clock` input, 1 bit: single system clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high. It overrides every other input.
- `partida` input, 1 bit: start request. It is sampled only in state INICIAL.
- `dados` input, 24 bits: six BCD digits. [23:20] is max digit 1, [19:16] is max digit 0, [15:12] is min digit 1, [11:8] is min digit 0, [7:4] is current digit 1 and [3:0] is current digit 0.
- `saida_serial` output, 1 bit: serial line, idle high.
- `ocupado` output, 1 bit: high from the cycle after acceptance until the frame completes.
- `pronto` output, 1 bit: one-cycle pulse when the frame ends.
- `db_estado` output, 4 bits: current FSM state code, for the hexa7seg display.

## Operation
- States and `db_estado` codes:
  - INICIAL = 0: idle.
  - PREPARA = 1: load the next character.
  - TRANSMITE = 2: shift bits out.
  - PROXIMO = 3: advance the character index.
  - FINAL = 15: pulse `pronto`.
- INICIAL:
  - `saida_serial` = 1, `ocupado` = 0.
  - When `partida` = 1, latch `dados` into an internal 24-bit register, clear the character index to 0, and go to PREPARA.
- PREPARA:
  - Character k (k = 0..5) is 0x30 | nibble, where nibble = latched[23-4k : 20-4k]. Character 0 is therefore max digit 1, sent first.
  - Nibbles above 9 are not checked; they are sent as 0x3A..0x3F.
  - Load the shift register as {stop, [parity], data[7:0], start = 0}, clear the bit counter and the baud counter, then go to TRANSMITE.
- TRANSMITE:
  - `saida_serial` = shift register bit 0.
  - Each bit is held for exactly `DIVISOR` cycles, then the register shifts right with 1 filled in.
  - After the last (stop) bit period, go to PROXIMO.
  - Data is sent LSB first.
- PROXIMO:
  - If the index is 5, go to FINAL.
  - Otherwise increment the index and go to PREPARA.
- FINAL: `pronto` = 1 for one cycle, then INICIAL.
- `partida` outside INICIAL is ignored. It is not queued.
- `dados` changes after acceptance have no effect on the frame in flight.
- `partida` held high continuously restarts a new frame on the cycle after FINAL returns to INICIAL.
- Reset in mid-frame:
  - Next cycle: state INICIAL, `saida_serial` = 1, `ocupado` = 0, `pronto` = 0, and all counters cleared.
  - The partially sent character is abandoned.
- Reset values: `saida_serial` = 1, `ocupado` = 0, `pronto` = 0, `db_estado` = 0.
- Counter widths:
  - Baud counter: $clog2(DIVISOR) bits. It wraps at DIVISOR-1 with no off-by-one.
  - Bit counter: 4 bits.
  - Character index: 3 bits. Values 6 and 7 are unreachable.

## Timing
- `partida` is high in cycle T, while in INICIAL.
  - T+1: state PREPARA, `ocupado` = 1, `saida_serial` still 1.
  - T+2: the start bit (0) appears on `saida_serial`.
- Each character occupies B·DIVISOR cycles in TRANSMITE, plus 2 overhead cycles (PROXIMO and PREPARA). B is 10, or 11 with parity.
- Between characters the line is held high (stop level) for those 2 overhead cycles.
- Total latency from `partida` to `pronto` is 1 + 6·(B·DIVISOR + 2) cycles. With DIVISOR = 4 and no parity this is 253 cycles.
- `pronto` is high only in FINAL, and `ocupado` is low in that same cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- `TRANSMISSOR_PARIDADE_EN` defined:
  - An even-parity bit (XOR of data[7:0]) is inserted between data bit 7 and the stop bit.
  - B = 11 and the bit counter terminates at 10.
- Not defined:
  - The frame is 8N1, with B = 10.
  - No parity logic is synthesized.

## Test plan
- Reset, then idle 20 cycles -> `saida_serial` = 1, `ocupado` = 0, `pronto` = 0, `db_estado` = 0 throughout.
- DIVISOR = 4, no macro, `dados` = 24'h987612, `partida` pulse -> bytes decoded from the line are 0x39 0x38 0x37 0x36 0x31 0x32 in order.
  - Each bit lasts 4 cycles.
  - `pronto` pulses exactly 253 cycles after `partida`.
- Change `dados` to 24'h000000 and pulse `partida` again during the third character -> the frame still completes with the original digits, and no second frame starts.
- Assert `reset` during character 2, bit 5 -> next cycle `saida_serial` = 1 and `db_estado` = 0.
  - A new `partida` afterwards sends a full correct frame.
- `TRANSMISSOR_PARIDADE_EN` defined, `dados` = 24'h000007 -> the last byte 0x37 has parity bit 1 and the first byte 0x30 has parity bit 0.
  - Total latency is 277 cycles.
- `partida` held high for 600 cycles -> two back-to-back frames, with `pronto` pulses 254 cycles apart.
  - 253 cycles of frame latency plus the single INICIAL cycle.
